// File: rtl/ascii_calculator.sv
// ascii_calculator: streaming ASCII integer calculator.
// Consumes one character per clock, evaluates left to right on '=',
// then converts the result to a right-justified 32-byte ASCII string.
module ascii_calculator (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   data,
  output logic [255:0] out0
);

  typedef enum logic [1:0] {IDLE, ACCUM, CONV} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  localparam logic [255:0] SPACES    = {32{8'h20}};
  localparam logic [255:0] ERROR_STR = {{27{8'h20}}, 40'h4552524f52};

  state_t       state, state_nxt;
  op_t          pend, op_in;
  logic [31:0]  acc, operand, applied, mag, q;
  logic [3:0]   r;
  logic [4:0]   idx;
  logic [255:0] shadow, shadow_nxt;
  logic         err, neg, div0, done;
  logic         is_digit, is_op, is_ign, is_eq;

  // Character classification and operator decode
  always_comb begin
    is_digit = (data >= 8'h30) && (data <= 8'h39);
    is_eq    = (data == 8'h3d);
    is_ign   = (data == 8'h20) || (data == 8'h0d) || (data == 8'h0a) || (data == 8'h00);
    op_in    = OP_NONE;
    case (data)
      8'h2b:   op_in = OP_ADD;
      8'h2d:   op_in = OP_SUB;
      8'h2a:   op_in = OP_MUL;
      8'h2f:   op_in = OP_DIV;
      default: op_in = OP_NONE;
    endcase
    is_op = (op_in != OP_NONE);
  end

  // Apply the pending operator to acc and the current operand
  always_comb begin
    applied = operand;
    div0    = 1'b0;
    case (pend)
      OP_ADD: applied = acc + operand;
      OP_SUB: applied = acc - operand;
      OP_MUL: applied = acc * operand;
      OP_DIV: begin
        if (operand == 32'd0) begin
          div0    = 1'b1;
          applied = acc;
        end else begin
          applied = $signed(acc) / $signed(operand);
        end
      end
      default: applied = operand;
    endcase
  end

  // One conversion step: peel off the lowest decimal digit of the magnitude
  always_comb begin
    q          = mag / 32'd10;
    r          = 4'(mag % 32'd10);
    shadow_nxt = shadow;
    shadow_nxt[{idx, 3'b000} +: 8] = {4'h3, r};
    if (neg && (q == 32'd0))
      shadow_nxt[{idx + 5'd1, 3'b000} +: 8] = 8'h2d;
    done = err || (q == 32'd0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!is_ign && !is_eq) state_nxt = ACCUM;
      ACCUM:   if (is_eq) state_nxt = CONV;
      CONV:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Expression datapath, conversion shadow and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      operand <= '0;
      pend    <= OP_NONE;
      err     <= 1'b0;
      mag     <= '0;
      neg     <= 1'b0;
      idx     <= '0;
      shadow  <= SPACES;
      out0    <= SPACES;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (is_digit) begin
            operand <= operand * 32'd10 + {28'd0, data[3:0]};
          end else if (is_op) begin
            acc     <= applied;
            err     <= err | div0;
            pend    <= op_in;
            operand <= '0;
          end else if (is_eq) begin
            // '=' only finishes a started expression; IDLE ignores it
            if (state == ACCUM) begin
              err    <= err | div0;
              neg    <= applied[31];
              mag    <= applied[31] ? (~applied + 32'd1) : applied;
              idx    <= '0;
              shadow <= SPACES;
            end
          end else if (!is_ign) begin
            err <= 1'b1;
          end
        end
        CONV: begin
          shadow <= shadow_nxt;
          mag    <= q;
          idx    <= idx + 5'd1;
          if (done) begin
            out0    <= err ? ERROR_STR : shadow_nxt;
            acc     <= '0;
            operand <= '0;
            pend    <= OP_NONE;
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_calculator.sv
// Self-checking bench for ascii_calculator: directed table, hand sequences,
// and random expressions checked against a string-level reference model.
module tb_ascii_calculator;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   data;
  logic [255:0] out0;

  int checks   = 0;
  int failures = 0;

  ascii_calculator dut (.clk(clk), .rst(rst), .data(data), .out0(out0));

  always #5 clk = ~clk;

  typedef struct {
    string expr;
    string res;
    int    lat;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [255:0] to_vec(input string s);
    logic [255:0] v;
    v = {32{8'h20}};
    for (int i = 0; i < s.len(); i++)
      v[8*i +: 8] = s[s.len()-1-i];
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: evaluate an expression string with plain int arithmetic
  function automatic string model(input string s);
    int acc, opd;
    logic [7:0] pend, c;
    bit err;
    acc = 0; opd = 0; pend = 8'h00; err = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        opd = opd * 10 + int'(c - 8'h30);
      end else if (c == "+" || c == "-" || c == "*" || c == "/" || c == "=") begin
        case (pend)
          "+": acc = acc + opd;
          "-": acc = acc - opd;
          "*": acc = acc * opd;
          "/": if (opd == 0) err = 1; else acc = acc / opd;
          default: acc = opd;
        endcase
        pend = c;
        opd  = 0;
        if (c == "=") break;
      end else if (!(c == 8'h20 || c == 8'h0d || c == 8'h0a || c == 8'h00)) begin
        err = 1;
      end
    end
    return err ? "ERROR" : $sformatf("%0d", acc);
  endfunction

  function automatic int lat_of(input string res);
    if (res == "ERROR") return 1;
    return (res[0] == "-") ? res.len() - 1 : res.len();
  endfunction

  task automatic send(input logic [7:0] c);
    data = c;
    @(posedge clk); #1;
  endtask

  // Stream an expression ending in '=', check hold before and load at latency
  task automatic run_expr(input string s, input string res, input int lat, input string name);
    logic [255:0] old;
    old = out0;
    for (int i = 0; i < s.len(); i++) send(s[i]);
    data = 8'h00;
    if (lat == 1) check({name, "_hold"}, out0, old);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == lat - 1) check({name, "_hold"}, out0, old);
    end
    check(name, out0, to_vec(res));
  endtask

  initial begin
    string s, res;
    logic [255:0] old;
    string ops;
    int n;

    rst = 1'b1; data = 8'h00;
    #12;
    check("reset_spaces", out0, {32{8'h20}});
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    tbl.push_back('{"12+34=",        "46",          2});
    tbl.push_back('{"2+3*4=",        "20",          2});
    tbl.push_back('{"7-10=",         "-3",          1});
    tbl.push_back('{"100/7=",        "14",          2});
    tbl.push_back('{"-9/2=",         "-4",          1});
    tbl.push_back('{"5/0=",          "ERROR",       1});
    tbl.push_back('{"2147483647+1=", "-2147483648", 10});
    tbl.push_back('{"3a+1=",         "ERROR",       1});
    tbl.push_back('{"0=",            "0",           1});
    tbl.push_back('{" 12 \r\n* 3=",  "36",          2});
    tbl.push_back('{"4294967297*3=", "3",           1});

    foreach (tbl[i]) run_expr(tbl[i].expr, tbl[i].res, tbl[i].lat, $sformatf("tbl%0d", i));

    // '=' alone in IDLE leaves out0 untouched
    old = out0;
    send("=");
    data = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    check("empty_eq_hold", out0, old);

    // Reset during conversion discards everything
    s = "123456789=";
    for (int i = 0; i < s.len(); i++) send(s[i]);
    data = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_conv", out0, {32{8'h20}});
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("reset_no_partial", out0, {32{8'h20}});
    run_expr("8=", "8", 1, "after_reset");

    // Random expressions against the reference model
    ops = "+-*/";
    for (int t = 0; t < 40; t++) begin
      s = "";
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        if (j > 0) s = {s, string'(ops[$urandom_range(0, 3)])};
        if ($urandom_range(0, 9) == 0) s = {s, " "};
        s = {s, $sformatf("%0d", ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 99999))};
      end
      s = {s, "="};
      res = model(s);
      run_expr(s, res, lat_of(res), $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
